ball_release_ctrl: RTL and testbench

BALL_RELEASE_CTRL -- requirements
Module: ball_release_ctrl

---
 rtl/tt_ctrl_pkg.sv | 34 +++
 rtl/ball_hopper.sv | 46 ++++
 rtl/ball_release_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ball_release_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_ctrl_pkg
//  Description : Shared state/colour types and default sizing for the
//                ball release controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package tt_ctrl_pkg;

    localparam int DEF_BLUE_COUNT = 8;
    localparam int DEF_RED_COUNT  = 8;
    localparam int DEF_TIMEOUT    = 64;
    localparam int DEF_CW         = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    typedef enum logic {
        BLUE = 1'b0,
        RED  = 1'b1
    } color_e;

    // The wait timer only has to hold TIMEOUT-1.
    function automatic int timer_width(input int timeout);
        return (timeout < 3) ? 2 : $clog2(timeout);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ball_hopper.sv
`default_nettype none
// ============================================================================
//  Module      : ball_hopper
//  Description : Ball counter for one hopper: parallel load, saturating
//                decrement, empty flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_hopper #(
    parameter int CW   = 5,
    parameter int INIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);

    localparam logic [CW-1:0] c_init = CW'(INIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = c_init;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= c_init;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ball_release_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ball_release_ctrl
//  Description : Sequences blue/red ball releases onto the board, follows
//                sink / interceptor returns and watches for lost balls.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_release_ctrl
    import tt_ctrl_pkg::*;
#(
    parameter int BLUE_COUNT = DEF_BLUE_COUNT,
    parameter int RED_COUNT  = DEF_RED_COUNT,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CW         = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_blue,
    input  logic          start_red,
    input  logic          reload,
    input  logic          blue_sink,
    input  logic          red_sink,
    input  logic          int_full,
    output logic          blue_ball,
    output logic          red_ball,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [CW-1:0] blue_left,
    output logic [CW-1:0] red_left
);

    localparam int              c_tw         = timer_width(TIMEOUT);
    localparam logic [c_tw-1:0] c_timer_last = c_tw'(TIMEOUT - 1);

    state_e          state_q;
    state_e          state_d;
    color_e          color_q;
    color_e          color_d;
    logic [c_tw-1:0] timer_q;
    logic [c_tw-1:0] timer_d;
    logic [c_tw-1:0] w_timer_inc;

    logic            w_load;
    logic            w_launch;
    color_e          w_launch_col;
    logic            w_hit_empty;
    logic            w_dec_blue;
    logic            w_dec_red;
    logic            w_blue_empty;
    logic            w_red_empty;

    ball_hopper #(
        .CW   (CW),
        .INIT (BLUE_COUNT)
    ) u_hopper_blue (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_load),
        .dec_i   (w_dec_blue),
        .count_o (blue_left),
        .empty_o (w_blue_empty)
    );

    ball_hopper #(
        .CW   (CW),
        .INIT (RED_COUNT)
    ) u_hopper_red (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_load),
        .dec_i   (w_dec_red),
        .count_o (red_left),
        .empty_o (w_red_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            color_q <= BLUE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            timer_q <= timer_d;
        end
    end

    // A start or a sink both request a launch; the launch is resolved once
    // below so the hopper decrement lands on the same edge as RELEASE entry.
    always_comb begin
        state_d      = state_q;
        color_d      = color_q;
        timer_d      = timer_q;
        w_load       = 1'b0;
        w_launch     = 1'b0;
        w_launch_col = BLUE;
        w_timer_inc  = timer_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (reload) begin
                    w_load = 1'b1;
                end else if (start_blue || start_red) begin
                    w_launch     = 1'b1;
                    w_launch_col = start_blue ? BLUE : RED;
                end
            end
            ST_RELEASE, ST_WAIT: begin
                timer_d = (state_q == ST_RELEASE) ? '0 : w_timer_inc;
                if (int_full) begin
                    state_d = ST_DONE;
                end else if (blue_sink && red_sink) begin
                    state_d = ST_FAULT;
                end else if (blue_sink || red_sink) begin
                    w_launch     = 1'b1;
                    w_launch_col = blue_sink ? BLUE : RED;
                end else if (state_q == ST_RELEASE) begin
                    state_d = ST_WAIT;
                end else if (w_timer_inc == c_timer_last) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DONE, ST_FAULT: begin
                if (reload) begin
                    w_load  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        w_hit_empty = (w_launch_col == BLUE) ? w_blue_empty : w_red_empty;
        if (w_launch) begin
            if (w_hit_empty) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RELEASE;
                color_d = w_launch_col;
                timer_d = '0;
            end
        end
    end

    assign w_dec_blue = w_launch && !w_hit_empty && (w_launch_col == BLUE);
    assign w_dec_red  = w_launch && !w_hit_empty && (w_launch_col == RED);

    // Pulses come straight from flops: the board loops them back to the sinks
    // combinationally within the release cycle.
    always_comb begin
        blue_ball = (state_q == ST_RELEASE) && (color_q == BLUE);
        red_ball  = (state_q == ST_RELEASE) && (color_q == RED);
        busy      = (state_q == ST_RELEASE) || (state_q == ST_WAIT);
        done      = (state_q == ST_DONE);
        fault     = (state_q == ST_FAULT);
    end

endmodule
`default_nettype wire

// File: tb/tb_ball_release_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_release_ctrl
//  Description : Self-checking bench: vector table, directed corner
//                sequences and a randomized run against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_release_ctrl;

    localparam int BC = 8;
    localparam int RC = 8;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_blue = 1'b0;
    logic       start_red  = 1'b0;
    logic       reload     = 1'b0;
    logic       blue_sink  = 1'b0;
    logic       red_sink   = 1'b0;
    logic       int_full   = 1'b0;
    logic       blue_ball, red_ball, busy, done, fault;
    logic [4:0] blue_left, red_left;
    logic       b3_blue_ball, b3_red_ball, b3_busy, b3_done, b3_fault;
    logic [4:0] b3_blue_left, b3_red_left;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_release_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_blue (start_blue),
        .start_red  (start_red),
        .reload     (reload),
        .blue_sink  (blue_sink),
        .red_sink   (red_sink),
        .int_full   (int_full),
        .blue_ball  (blue_ball),
        .red_ball   (red_ball),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .blue_left  (blue_left),
        .red_left   (red_left)
    );

    ball_release_ctrl #(.BLUE_COUNT(3)) dut_b3 (
        .clk        (clk),
        .rst        (rst),
        .start_blue (start_blue),
        .start_red  (start_red),
        .reload     (reload),
        .blue_sink  (blue_sink),
        .red_sink   (red_sink),
        .int_full   (int_full),
        .blue_ball  (b3_blue_ball),
        .red_ball   (b3_red_ball),
        .busy       (b3_busy),
        .done       (b3_done),
        .fault      (b3_fault),
        .blue_left  (b3_blue_left),
        .red_left   (b3_red_left)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int bb, input int rb, input int bz,
                            input int dn, input int ft, input int bl, input int rl);
        chk({tag, "_blue_ball"}, int'(blue_ball), bb);
        chk({tag, "_red_ball"},  int'(red_ball),  rb);
        chk({tag, "_busy"},      int'(busy),      bz);
        chk({tag, "_done"},      int'(done),      dn);
        chk({tag, "_fault"},     int'(fault),     ft);
        chk({tag, "_blue_left"}, int'(blue_left), bl);
        chk({tag, "_red_left"},  int'(red_left),  rl);
    endtask

    // Reference model: game phase, colour in flight, balls left, cycles since release.
    localparam int P_IDLE = 0, P_REL = 1, P_WAIT = 2, P_DONE = 3, P_FAULT = 4;
    int m_phase, m_col, m_elapsed;
    int m_left [2];

    task automatic model_reset();
        m_phase = P_IDLE; m_col = 0; m_elapsed = 0;
        m_left[0] = BC; m_left[1] = RC;
    endtask

    task automatic model_launch(input int c);
        if (m_left[c] > 0) begin
            m_left[c] = m_left[c] - 1;
            m_phase = P_REL; m_col = c; m_elapsed = 0;
        end else begin
            m_phase = P_DONE;
        end
    endtask

    task automatic model_step();
        if (m_phase == P_REL || m_phase == P_WAIT) begin
            if (int_full) m_phase = P_DONE;
            else if (blue_sink && red_sink) m_phase = P_FAULT;
            else if (blue_sink) model_launch(0);
            else if (red_sink) model_launch(1);
            else begin
                m_elapsed++;
                m_phase = (m_elapsed >= TO) ? P_FAULT : P_WAIT;
            end
        end else if (reload) begin
            m_left[0] = BC; m_left[1] = RC; m_phase = P_IDLE;
        end else if (m_phase == P_IDLE && start_blue) model_launch(0);
        else if (m_phase == P_IDLE && start_red) model_launch(1);
    endtask

    task automatic model_cycle();
        @(negedge clk);
        chk_outs("rand",
                 int'(m_phase == P_REL && m_col == 0), int'(m_phase == P_REL && m_col == 1),
                 int'(m_phase == P_REL || m_phase == P_WAIT), int'(m_phase == P_DONE),
                 int'(m_phase == P_FAULT), m_left[0], m_left[1]);
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        start_blue = 0; start_red = 0; reload = 0;
        blue_sink = 0; red_sink = 0; int_full = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, BC, RC);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    typedef struct {
        int sb, sr, bs, rs, ifl, rl;
        int bb, rb, bz, dn, ft, bl, rlc;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int pulses, gaps, busy_cnt, b3_red_pulses;

        vecs = '{
            '{1,0,0,0,0,0, 1,0,1,0,0, 7,8},
            '{0,0,0,0,0,0, 0,0,1,0,0, 7,8},
            '{0,0,1,0,0,0, 1,0,1,0,0, 6,8},
            '{0,0,0,1,0,0, 0,1,1,0,0, 6,7},
            '{1,0,0,0,0,0, 0,0,1,0,0, 6,7},
            '{0,0,0,0,0,1, 0,0,1,0,0, 6,7},
            '{0,0,0,0,1,0, 0,0,0,1,0, 6,7},
            '{0,1,0,0,0,0, 0,0,0,1,0, 6,7},
            '{0,0,0,0,0,1, 0,0,0,0,0, 8,8},
            '{1,1,0,0,0,0, 1,0,1,0,0, 7,8},
            '{0,0,1,1,1,0, 0,0,0,1,0, 7,8},
            '{0,0,0,0,0,1, 0,0,0,0,0, 8,8},
            '{0,1,0,0,0,0, 0,1,1,0,0, 8,7},
            '{0,0,1,1,0,0, 0,0,0,0,1, 8,7},
            '{0,0,1,0,0,0, 0,0,0,0,1, 8,7},
            '{0,0,0,0,0,1, 0,0,0,0,0, 8,8}
        };

        do_reset();
        for (int i = 0; i < 16; i++) begin
            start_blue = vecs[i].sb[0]; start_red = vecs[i].sr[0];
            blue_sink  = vecs[i].bs[0]; red_sink  = vecs[i].rs[0];
            int_full   = vecs[i].ifl[0]; reload   = vecs[i].rl[0];
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].bb, vecs[i].rb, vecs[i].bz,
                     vecs[i].dn, vecs[i].ft, vecs[i].bl, vecs[i].rlc);
        end
        clear_inputs();

        // Red run with the sink looped back from the pulse in the same cycle.
        do_reset();
        start_red = 1; tick(); start_red = 0;
        pulses = 0; gaps = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (red_ball) begin
                pulses++;
                chk($sformatf("loop_red_left_p%0d", pulses), int'(red_left), RC - pulses);
            end else begin
                gaps++;
            end
            red_sink = red_ball;
            tick();
        end
        red_sink = 0;
        chk("loop_pulses", pulses, 8);
        chk("loop_gaps", gaps, 0);
        chk("loop_done", int'(done), 1);
        chk("loop_red_left", int'(red_left), 0);
        chk("loop_blue_left", int'(blue_left), BC);

        // Three-ball blue hopper, interceptor catches the second release.
        do_reset();
        start_blue = 1; tick(); start_blue = 0;
        pulses = 0; b3_red_pulses = 0;
        for (int c = 0; c < 40 && !b3_done; c++) begin
            blue_sink = 0; int_full = 0;
            if (b3_red_ball) b3_red_pulses++;
            if (b3_blue_ball) begin
                pulses++;
                if (pulses == 1) blue_sink = 1;
                else int_full = 1;
            end
            tick();
        end
        clear_inputs();
        chk("intc_pulses", pulses, 2);
        chk("intc_done", int'(b3_done), 1);
        chk("intc_blue_left", int'(b3_blue_left), 1);
        chk("intc_red_left", int'(b3_red_left), RC);
        chk("intc_red_pulses", b3_red_pulses, 0);
        chk("intc_busy", int'(b3_busy), 0);
        chk("intc_fault", int'(b3_fault), 0);

        // Lost ball: watchdog must trip after the full busy window.
        do_reset();
        start_blue = 1; tick(); start_blue = 0;
        pulses = 0; busy_cnt = 0;
        for (int c = 0; c < 200 && !fault; c++) begin
            if (busy) busy_cnt++;
            if (blue_ball) pulses++;
            tick();
        end
        chk("tmo_busy_cycles", busy_cnt, TO);
        chk("tmo_pulses", pulses, 1);
        chk("tmo_fault", int'(fault), 1);
        reload = 1; tick(); reload = 0;
        chk_outs("tmo_reload", 0, 0, 0, 0, 0, BC, RC);

        // Both sinks together while waiting.
        do_reset();
        start_blue = 1; tick(); start_blue = 0;
        tick();
        chk_outs("dual_wait", 0, 0, 1, 0, 0, 7, 8);
        blue_sink = 1; red_sink = 1; tick(); clear_inputs();
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            if (blue_ball || red_ball) pulses++;
            tick();
        end
        chk("dual_fault", int'(fault), 1);
        chk("dual_no_pulse", pulses, 0);

        // Asynchronous reset in the middle of a release.
        do_reset();
        start_blue = 1; @(posedge clk); #2; start_blue = 0;
        chk("areset_pre_pulse", int'(blue_ball), 1);
        rst = 1; #1;
        chk_outs("areset", 0, 0, 0, 0, 0, BC, RC);
        @(negedge clk); rst = 0;
        tick();
        model_reset();

        // Randomized run against the reference model.
        for (int c = 0; c < 3000; c++) begin
            start_blue = ($urandom_range(0, 9) == 0);
            start_red  = ($urandom_range(0, 9) == 0);
            reload     = ($urandom_range(0, 24) == 0);
            int_full   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) < 60) begin
                blue_sink = blue_ball;
                red_sink  = red_ball;
            end else begin
                blue_sink = ($urandom_range(0, 14) == 0);
                red_sink  = ($urandom_range(0, 14) == 0);
            end
            model_cycle();
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
